execute_pipe: RTL and testbench
===============================

// Module: execute_pipe
// PURPOSE
// - Pipelined SIMD execute stage: PE_COUNT lanes apply one op per beat, giving an element-wise vector result and a cross-lane dot product.
// - Valid/ready handshake on input and element output; configurable pipeline depth.
// - Dot products accumulate over multi-beat sequences framed by dot_first/dot_last; no free-running enable toggle.
// - Sits between the operand-fetch stage and writeback.
// PARAMETERS
// - PE_COUNT     4                 number of lanes
// - DATA_WIDTH   32                lane operand/result width, signed two's complement
// - PIPE_STAGES  2                 element-path register stages, >=1
// - ACC_WIDTH    2*DATA_WIDTH+16   dot accumulator/output width, signed
// PORTS
// - clk         in   1                     clock, all logic on posedge
// - rst         in   1                     synchronous reset, active-high
// - in_valid    in   1                     input beat valid
// - in_ready    out  1                     input beat accepted when in_valid&&in_ready
// - a, b        in   PE_COUNT*DATA_WIDTH   signed lane operands, packed [PE_COUNT-1:0][DATA_WIDTH-1:0]
// - op          in   3                     000 ADD,001 SUB,010 MUL,011 AND,100 OR,101 XOR,110 PASS_A,111 MAX(signed)
// - dot_en      in   1                     beat contributes to dot accumulator
// - dot_first   in   1                     beat starts a new dot sequence (qualified by dot_en)
// - dot_last    in   1                     beat ends dot sequence (qualified by dot_en)
// - elem_valid  out  1                     elem_out valid
// - elem_ready  in   1                     downstream accepts elem_out
// - elem_out    out  PE_COUNT*DATA_WIDTH   per-lane op result
// - dot_valid   out  1                     one-cycle pulse, dot_out holds finished sum
// - dot_out     out  ACC_WIDTH             dot product result, held until next dot_valid
// - dot_sat     out  1                     saturation occurred in the reported sequence
// BEHAVIOUR
// - Reset: all stage valids, elem_out, elem_valid, dot_out, dot_valid, dot_sat, accumulator -> 0; in_ready=0 while rst=1.
// - Reset mid-operation: in-flight beats and partial dot sum discarded; no dot_valid emitted for them.
// - Lane ops computed in stage 0 from a,b,op; results truncated to DATA_WIDTH (MUL keeps low bits, ADD/SUB wrap).
// - Each beat also carries lane products a[i]*b[i] at full 2*DATA_WIDTH signed, summed across lanes,
//   sign-extended to ACC_WIDTH, travelling with the beat; dot_en/first/last travel alongside.
// - Pipeline: stage k advances when empty or stage k+1 advances; final stage advances on elem_ready.
// - in_ready = !stage0_valid || stage0_advances (combinational; no combinational path in_valid->in_ready).
// - Latency: beat accepted at cycle t appears with elem_valid at t+PIPE_STAGES if never stalled.
// - Throughput 1 beat/cycle; elem_ready=0 freezes all full stages, elem_out stable, no beat dropped/duplicated.
// - Accumulation only at output handshake (elem_valid&&elem_ready) of a beat with dot_en=1:
//   dot_first=1 -> acc=lane_sum; else acc=acc+lane_sum.
// - dot_last=1 on that beat -> next cycle dot_out=new acc, dot_valid=1 for exactly one cycle; acc keeps value.
// - dot_first&&dot_last same beat: single-beat dot product.
// - dot_en=0 beats: accumulator untouched, flags ignored.
// - dot_last without preceding dot_first: adds to existing acc (legal, continues previous value).
// - dot_valid has no backpressure; consumer samples on the pulse.
// - Overflow without macro: accumulator wraps at ACC_WIDTH; dot_sat constant 0.
// CONFIGURATION
// - EXEC_DOT_SAT_EN defined: accumulator add saturates to signed ACC_WIDTH max/min;
//   sticky sat flag cleared by dot_first, set on any clamp; copied to dot_sat with each dot_valid.
// - EXEC_DOT_SAT_EN undefined: wrap-around arithmetic, dot_sat tied 0, no saturation logic.
// TESTING
// - ADD a={1,2,3,4}, b={10,20,30,40}, elem_ready=1 -> elem_out={11,22,33,44}, elem_valid 2 cycles after accept.
// - Dot 2 beats: a={1,2,3,4},b={1,1,1,1} first; a={2,2,2,2},b={3,3,3,3} last -> dot_out=34, dot_valid 1 cycle.
// - elem_ready=0 for 6 cycles while streaming 4 beats -> in_ready drops after PIPE_STAGES beats held; order kept.
// - MUL lane0 a=32'h0001_0000,b=32'h0001_0000, others 0, first&last -> elem lane0=0, dot_out=64'h1_0000_0000.
// - ACC_WIDTH=64, all lanes a=b=-2^31, first&last -> macro on: dot_out=2^63-1, dot_sat=1; macro off: dot_out=0.
// - rst=1 between first and last beats -> all outputs 0, no dot_valid; new first+last beat gives clean sum.

Source files
------------

// File: rtl/execute_pipe_if.sv
// execute_pipe_if: bundles the operand-fetch -> execute -> writeback handshakes.
//   in_valid/in_ready + a, b, op, dot_en, dot_first, dot_last : input beat
//   elem_valid/elem_ready + elem_out                          : element result stream
//   dot_valid, dot_out, dot_sat                                : dot product report (no backpressure)
// master: the side driving beats and consuming results. slave: the execute stage.
interface execute_pipe_if #(
  parameter int unsigned PE_COUNT   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 16
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  a;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  b;
  logic [2:0]                           op;
  logic                                 dot_en;
  logic                                 dot_first;
  logic                                 dot_last;
  logic                                 elem_valid;
  logic                                 elem_ready;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  elem_out;
  logic                                 dot_valid;
  logic [ACC_WIDTH-1:0]                 dot_out;
  logic                                 dot_sat;

  modport master (
    output in_valid, a, b, op, dot_en, dot_first, dot_last, elem_ready,
    input  in_ready, elem_valid, elem_out, dot_valid, dot_out, dot_sat
  );

  modport slave (
    input  in_valid, a, b, op, dot_en, dot_first, dot_last, elem_ready,
    output in_ready, elem_valid, elem_out, dot_valid, dot_out, dot_sat
  );
endinterface

// File: rtl/execute_pipe.sv
// execute_pipe: pipelined SIMD execute stage.
// PE_COUNT lanes apply one op per beat (ADD, SUB, MUL, AND, OR, XOR, PASS_A, signed MAX) and
// each beat also carries the cross-lane sum of full-width signed products a[i]*b[i]. Beats
// retire through a PIPE_STAGES-deep elastic pipeline; at the output handshake, beats with
// dot_en fold their lane sum into a dot accumulator framed by dot_first/dot_last.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : execute_pipe_if.slave (input beat, element result stream, dot report)
// Optional feature macro: EXEC_DOT_SAT_EN -- saturating accumulator with sticky dot_sat.
// Without it the accumulator wraps at ACC_WIDTH and dot_sat is tied 0.
module execute_pipe #(
  parameter int unsigned PE_COUNT    = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned ACC_WIDTH   = 2 * DATA_WIDTH + 16
) (
  input logic           clk,
  input logic           rst,
  execute_pipe_if.slave bus
);

  localparam int unsigned LAST  = PIPE_STAGES - 1;
  // Exact width of the per-beat lane-product sum.
  localparam int unsigned SUM_W = 2 * DATA_WIDTH + $clog2(PE_COUNT) + 1;
  // One guard bit above the wider of accumulator and lane sum, so acc + sum never overflows.
  localparam int unsigned EXT_W = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;

  typedef logic [PE_COUNT-1:0][DATA_WIDTH-1:0] lanes_t;

  // Stage 0 combinational compute
  lanes_t                        elem_c;
  logic signed [SUM_W-1:0]       sum_c;
  logic signed [2*DATA_WIDTH-1:0] ax, bx, prod;

  always_comb begin
    elem_c = '0;
    sum_c  = '0;
    ax     = '0;
    bx     = '0;
    prod   = '0;
    for (int i = 0; i < int'(PE_COUNT); i++) begin
      ax   = {{DATA_WIDTH{bus.a[i][DATA_WIDTH-1]}}, bus.a[i]};
      bx   = {{DATA_WIDTH{bus.b[i][DATA_WIDTH-1]}}, bus.b[i]};
      prod = ax * bx;
      sum_c = sum_c + {{(SUM_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
      case (bus.op)
        3'b000:  elem_c[i] = bus.a[i] + bus.b[i];
        3'b001:  elem_c[i] = bus.a[i] - bus.b[i];
        3'b010:  elem_c[i] = prod[DATA_WIDTH-1:0];
        3'b011:  elem_c[i] = bus.a[i] & bus.b[i];
        3'b100:  elem_c[i] = bus.a[i] | bus.b[i];
        3'b101:  elem_c[i] = bus.a[i] ^ bus.b[i];
        3'b111:  elem_c[i] = ($signed(bus.a[i]) > $signed(bus.b[i])) ? bus.a[i] : bus.b[i];
        default: elem_c[i] = bus.a[i];
      endcase
    end
  end

  // Pipeline registers
  logic   [PIPE_STAGES-1:0]     valid_q, den_q, dfirst_q, dlast_q;
  lanes_t                       elem_q [PIPE_STAGES];
  logic signed [SUM_W-1:0]      sum_q  [PIPE_STAGES];
  logic   [PIPE_STAGES-1:0]     adv;
  logic                         full_run;

  // Stage k may load when any stage from k to the output is empty, or the output drains.
  always_comb begin
    full_run = 1'b1;
    adv      = '0;
    for (int k = int'(PIPE_STAGES) - 1; k >= 0; k--) begin
      full_run = full_run & valid_q[k];
      adv[k]   = bus.elem_ready | ~full_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      den_q    <= '0;
      dfirst_q <= '0;
      dlast_q  <= '0;
      for (int k = 0; k < int'(PIPE_STAGES); k++) begin
        elem_q[k] <= '0;
        sum_q[k]  <= '0;
      end
    end else begin
      if (adv[0]) begin
        valid_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          elem_q[0]   <= elem_c;
          sum_q[0]    <= sum_c;
          den_q[0]    <= bus.dot_en;
          dfirst_q[0] <= bus.dot_first;
          dlast_q[0]  <= bus.dot_last;
        end
      end
      for (int k = 1; k < int'(PIPE_STAGES); k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            elem_q[k]   <= elem_q[k-1];
            sum_q[k]    <= sum_q[k-1];
            den_q[k]    <= den_q[k-1];
            dfirst_q[k] <= dfirst_q[k-1];
            dlast_q[k]  <= dlast_q[k-1];
          end
        end
      end
    end
  end

  assign bus.in_ready   = adv[0] & ~rst;
  assign bus.elem_valid = valid_q[LAST];
  assign bus.elem_out   = elem_q[LAST];

  // Dot accumulator, updated only on the output handshake of a dot_en beat
  logic                       take;
  logic [ACC_WIDTH-1:0]       acc_q, acc_d, acc_res;
  logic signed [EXT_W-1:0]    acc_ext, sum_ext, total;
  logic                       dot_valid_q;
  logic [ACC_WIDTH-1:0]       dot_out_q;

`ifdef EXEC_DOT_SAT_EN
  localparam logic signed [EXT_W-1:0] AccMax =
      {{(EXT_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] AccMin =
      {{(EXT_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  logic clamp, sat_q, sat_d, dot_sat_q;
`else
  logic unused_total_hi;
  assign unused_total_hi = ^total[EXT_W-1:ACC_WIDTH];
`endif

  always_comb begin
    take    = valid_q[LAST] & bus.elem_ready & den_q[LAST];
    acc_ext = dfirst_q[LAST] ? '0 : {{(EXT_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
    sum_ext = {{(EXT_W-SUM_W){sum_q[LAST][SUM_W-1]}}, sum_q[LAST]};
    total   = acc_ext + sum_ext;
    acc_res = total[ACC_WIDTH-1:0];
`ifdef EXEC_DOT_SAT_EN
    clamp = 1'b0;
    if (total > AccMax) begin
      acc_res = AccMax[ACC_WIDTH-1:0];
      clamp   = 1'b1;
    end else if (total < AccMin) begin
      acc_res = AccMin[ACC_WIDTH-1:0];
      clamp   = 1'b1;
    end
    // Sticky across the sequence; dot_first starts a clean one.
    sat_d = take ? ((dfirst_q[LAST] ? 1'b0 : sat_q) | clamp) : sat_q;
`endif
    acc_d = take ? acc_res : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      dot_valid_q <= 1'b0;
      dot_out_q   <= '0;
`ifdef EXEC_DOT_SAT_EN
      sat_q       <= 1'b0;
      dot_sat_q   <= 1'b0;
`endif
    end else begin
      acc_q       <= acc_d;
      dot_valid_q <= take & dlast_q[LAST];
      if (take && dlast_q[LAST]) begin
        dot_out_q <= acc_d;
      end
`ifdef EXEC_DOT_SAT_EN
      sat_q <= sat_d;
      if (take && dlast_q[LAST]) begin
        dot_sat_q <= sat_d;
      end
`endif
    end
  end

  assign bus.dot_valid = dot_valid_q;
  assign bus.dot_out   = dot_out_q;
`ifdef EXEC_DOT_SAT_EN
  assign bus.dot_sat   = dot_sat_q;
`else
  assign bus.dot_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_execute_pipe.sv
module tb_execute_pipe;
  localparam int unsigned PE = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned PS = 2;
  localparam int unsigned AW = 2 * DW + 16;

  typedef logic [PE-1:0][DW-1:0] lanes_t;
  typedef logic signed [127:0]   wide_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_pipe_if #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();
  execute_pipe #(.PE_COUNT(PE), .DATA_WIDTH(DW), .PIPE_STAGES(PS), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Narrow-accumulator instance for the overflow corner case
  execute_pipe_if #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ACC_WIDTH(64)) bus64 ();
  execute_pipe #(.PE_COUNT(PE), .DATA_WIDTH(DW), .PIPE_STAGES(PS), .ACC_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .bus(bus64)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model
  function automatic lanes_t model_elem(input logic [2:0] op, input lanes_t a, input lanes_t b);
    lanes_t r;
    int x, y;
    for (int i = 0; i < int'(PE); i++) begin
      x = int'(a[i]);
      y = int'(b[i]);
      case (op)
        3'd0: r[i] = x + y;
        3'd1: r[i] = x - y;
        3'd2: r[i] = x * y;
        3'd3: r[i] = x & y;
        3'd4: r[i] = x | y;
        3'd5: r[i] = x ^ y;
        3'd6: r[i] = x;
        default: r[i] = (x > y) ? x : y;
      endcase
    end
    return r;
  endfunction

  function automatic wide_t model_sum(input lanes_t a, input lanes_t b);
    wide_t s = 0;
    for (int i = 0; i < int'(PE); i++)
      s += wide_t'(longint'(int'(a[i])) * longint'(int'(b[i])));
    return s;
  endfunction

  function automatic wide_t fit(input wide_t x, input int w, output bit clamp);
    wide_t mx = (wide_t'(1) <<< (w - 1)) - 1;
    wide_t mn = -(wide_t'(1) <<< (w - 1));
    clamp = 1'b0;
`ifdef EXEC_DOT_SAT_EN
    if (x > mx) begin clamp = 1'b1; return mx; end
    if (x < mn) begin clamp = 1'b1; return mn; end
    return x;
`else
    if (mx < mn) clamp = 1'b1; // never true; keeps mx/mn referenced
    return (x <<< (128 - w)) >>> (128 - w);
`endif
  endfunction

  typedef struct {
    lanes_t elem;
    wide_t  sum;
    bit     en, first, last;
  } exp_t;

  exp_t  q[$];
  wide_t m_acc = 0;
  bit    m_sat = 0;
  bit    dot_pend = 0;
  wide_t dot_exp = 0;
  bit    sat_exp = 0;

  // Scoreboard: every accepted beat must emerge once, in order, with model-computed results
  always @(negedge clk) begin
    exp_t e;
    bit   c;
    wide_t t;
    if (rst) begin
      q.delete();
      m_acc = 0; m_sat = 0; dot_pend = 0;
    end else begin
      chk("mon_dot_valid", bus.dot_valid, dot_pend);
      if (dot_pend) begin
        chk("mon_dot_out", bus.dot_out, dot_exp[AW-1:0]);
        chk("mon_dot_sat", bus.dot_sat, sat_exp);
      end
      dot_pend = 0;
      if (bus.elem_valid && bus.elem_ready) begin
        if (q.size() == 0) chk("mon_spurious_elem", bus.elem_valid, 1'b0);
        else begin
          e = q.pop_front();
          chk("mon_elem_out", bus.elem_out, e.elem);
          if (e.en) begin
            t = e.first ? e.sum : m_acc + e.sum;
            m_acc = fit(t, AW, c);
            m_sat = (e.first ? 1'b0 : m_sat) | c;
            if (e.last) begin dot_pend = 1; dot_exp = m_acc; sat_exp = m_sat; end
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.elem = model_elem(bus.op, bus.a, bus.b);
        e.sum = model_sum(bus.a, bus.b);
        e.en = bus.dot_en; e.first = bus.dot_first; e.last = bus.dot_last;
        q.push_back(e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic [2:0] op, input lanes_t a, input lanes_t b,
                       input bit en, input bit f, input bit l);
    bus.op = op; bus.a = a; bus.b = b;
    bus.dot_en = en; bus.dot_first = f; bus.dot_last = l;
  endtask

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input logic [2:0] op, input lanes_t a, input lanes_t b,
                      input bit en, input bit f, input bit l);
    int n = 0;
    drive(op, a, b, en, f, l);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) chk("send_timeout", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_elem(output lanes_t v, output int cycles);
    cycles = 0;
    do begin @(negedge clk); cycles++; end
    while (!(bus.elem_valid && bus.elem_ready) && cycles < 50);
    if (!(bus.elem_valid && bus.elem_ready)) chk("elem_timeout", bus.elem_valid, 1'b1);
    v = bus.elem_out;
    @(posedge clk); #1;
  endtask

  task automatic wait_dot(output logic [AW-1:0] v, output bit s);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.dot_valid && n < 50);
    chk("dot_seen", bus.dot_valid, 1'b1);
    v = bus.dot_out;
    s = bus.dot_sat;
    @(negedge clk);
    chk("dot_pulse_one_cycle", bus.dot_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0] op;
    lanes_t     a, b, exp;
  } vec_t;

  initial begin
    vec_t tbl[8];
    lanes_t got, snap;
    logic [AW-1:0] dv;
    bit ds, accd, have_snap;
    int lat, idx, cnt;

    tbl[0] = '{3'd0, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd10, 32'd20, 32'd30, 32'd40},
               {32'd11, 32'd22, 32'd33, 32'd44}};
    tbl[1] = '{3'd1, {32'd5, 32'd0, 32'd100, 32'hFFFF_FFFF}, {32'd7, 32'd1, 32'd1, 32'd1},
               {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd99, 32'hFFFF_FFFE}};
    tbl[2] = '{3'd2, {32'd3, 32'h0001_0000, 32'hFFFF_FFFE, 32'd7},
               {32'd4, 32'h0001_0000, 32'd5, 32'd6}, {32'd12, 32'd0, 32'hFFFF_FFF6, 32'd42}};
    tbl[3] = '{3'd3, {32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678},
               {32'hFF00_FF00, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0F0F_0F0F},
               {32'hF000_F000, 32'h0000_FFFF, 32'd0, 32'h0204_0608}};
    tbl[4] = '{3'd4, tbl[3].a, tbl[3].b,
               {32'hFFF0_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1F3F_5F7F}};
    tbl[5] = '{3'd5, tbl[3].a, tbl[3].b,
               {32'h0FF0_0FF0, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h1D3B_5977}};
    tbl[6] = '{3'd6, {32'd9, 32'd8, 32'd7, 32'd6}, {32'd1, 32'd1, 32'd1, 32'd1},
               {32'd9, 32'd8, 32'd7, 32'd6}};
    tbl[7] = '{3'd7, {32'hFFFF_FFFB, 32'd3, 32'h8000_0000, 32'h7FFF_FFFF},
               {32'd2, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000},
               {32'd2, 32'd3, 32'h7FFF_FFFF, 32'h7FFF_FFFF}};

    bus.in_valid = 0; bus.elem_ready = 1;
    drive(3'd0, '0, '0, 0, 0, 0);
    bus64.in_valid = 0; bus64.elem_ready = 1; bus64.op = 3'd0;
    bus64.a = '0; bus64.b = '0; bus64.dot_en = 0; bus64.dot_first = 0; bus64.dot_last = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_elem_valid", bus.elem_valid, 1'b0);
    chk("rst_elem_out", bus.elem_out, '0);
    chk("rst_dot_valid", bus.dot_valid, 1'b0);
    chk("rst_dot_out", bus.dot_out, '0);
    chk("rst_dot_sat", bus.dot_sat, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Table of lane ops
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, 0, 0, 0);
      wait_elem(got, lat);
      chk($sformatf("table_op%0d", i), got, tbl[i].exp);
    end

    // Latency of an unstalled beat
    send(tbl[0].op, tbl[0].a, tbl[0].b, 0, 0, 0);
    wait_elem(got, lat);
    chk("latency", lat, PS);
    chk("latency_elem", got, tbl[0].exp);

    // Two-beat dot product: 10 + 24
    send(3'd0, {32'd1, 32'd2, 32'd3, 32'd4}, {4{32'd1}}, 1, 1, 0);
    send(3'd0, {4{32'd2}}, {4{32'd3}}, 1, 0, 1);
    wait_dot(dv, ds);
    chk("dot_two_beat", dv, 80'd34);

    // Backpressure: 6 stalled cycles while streaming 4 beats
    bus.elem_ready = 0; idx = 0; have_snap = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) begin
        drive(3'd0, {4{32'(idx + 1)}}, {4{32'd10}}, 0, 0, 0);
        bus.in_valid = 1;
      end else bus.in_valid = 0;
      @(negedge clk);
      accd = bus.in_valid && bus.in_ready;
      if (bus.elem_valid) begin
        if (!have_snap) begin snap = bus.elem_out; have_snap = 1; end
        else chk("stall_stable", bus.elem_out, snap);
      end
      @(posedge clk); #1;
      if (accd) idx++;
    end
    chk("stall_accepted", idx, PS);
    chk("stall_in_ready_low", bus.in_ready, 1'b0);
    chk("stall_head", snap, {4{32'd11}});
    bus.elem_ready = 1; cnt = 0;
    while (idx < 4 && cnt < 20) begin
      drive(3'd0, {4{32'(idx + 1)}}, {4{32'd10}}, 0, 0, 0);
      bus.in_valid = 1;
      @(negedge clk);
      accd = bus.in_ready;
      @(posedge clk); #1;
      if (accd) idx++;
      cnt++;
    end
    bus.in_valid = 0;
    chk("stall_all_sent", idx, 4);
    repeat (6) @(posedge clk); #1;
    chk("stall_drained", q.size(), 0);

    // MUL wrap in lane 0, full-width product in the dot path
    send(3'd2, {32'd0, 32'd0, 32'd0, 32'h0001_0000}, {32'd0, 32'd0, 32'd0, 32'h0001_0000},
         1, 1, 1);
    wait_elem(got, lat);
    chk("mul_lane0", got[0], 32'd0);
    wait_dot(dv, ds);
    chk("mul_dot", dv, 80'h1_0000_0000);
    chk("mul_dot_sat", ds, 1'b0);

    // Four -2^31 * -2^31 products: 2^64 fits in the default accumulator
    send(3'd2, {4{32'h8000_0000}}, {4{32'h8000_0000}}, 1, 1, 1);
    wait_dot(dv, ds);
    chk("big_dot", dv, 80'h1_0000_0000_0000_0000);

    // Same on a 64-bit accumulator: overflows
    bus64.op = 3'd2; bus64.a = {4{32'h8000_0000}}; bus64.b = {4{32'h8000_0000}};
    bus64.dot_en = 1; bus64.dot_first = 1; bus64.dot_last = 1; bus64.in_valid = 1;
    @(negedge clk);
    chk("sat64_in_ready", bus64.in_ready, 1'b1);
    @(posedge clk); #1;
    bus64.in_valid = 0; cnt = 0;
    do begin @(negedge clk); cnt++; end while (!bus64.dot_valid && cnt < 20);
    chk("sat64_dot_valid", bus64.dot_valid, 1'b1);
`ifdef EXEC_DOT_SAT_EN
    chk("sat64_dot_out", bus64.dot_out, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sat64_dot_sat", bus64.dot_sat, 1'b1);
`else
    chk("sat64_dot_out", bus64.dot_out, 64'd0);
    chk("sat64_dot_sat", bus64.dot_sat, 1'b0);
`endif
    @(posedge clk); #1;

    // Reset between first and last of a dot sequence
    send(3'd0, {32'd1, 32'd2, 32'd3, 32'd4}, {4{32'd1}}, 1, 1, 0);
    wait_elem(got, lat);
    send(3'd0, {4{32'd5}}, {4{32'd5}}, 1, 0, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    chk("midrst_elem_valid", bus.elem_valid, 1'b0);
    chk("midrst_elem_out", bus.elem_out, '0);
    chk("midrst_dot_valid", bus.dot_valid, 1'b0);
    chk("midrst_dot_out", bus.dot_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    send(3'd0, {4{32'd2}}, {4{32'd3}}, 1, 1, 1);
    wait_dot(dv, ds);
    chk("midrst_clean_dot", dv, 80'd24);

    // Randomized traffic against the scoreboard
    bus.in_valid = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      accd = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (accd || !bus.in_valid) begin
        lanes_t ra, rb;
        for (int i = 0; i < int'(PE); i++) begin
          ra[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
          rb[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
        end
        drive(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        bus.in_valid = $urandom_range(0, 3) != 0;
      end
      bus.elem_ready = $urandom_range(0, 3) != 0;
    end
    bus.in_valid = 0;
    bus.elem_ready = 1;
    repeat (10) @(posedge clk); #1;
    chk("random_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
